menu_select: RTL and testbench

- Upstream companion of the menu drawing stage.
- Takes raw mouse coordinates and the left button from the mouse controller. Clamps the coordinates and latches them once per frame, then feeds them to the menu drawing stage as mouse_x/mouse_y.
- Hit-tests the three menu buttons (one player, two players, settings) and debounces the click.
- Runs a press/release selection FSM that delivers the chosen button to the top-level game controller through a valid/ack handshake.

---
 rtl/menu_select_if.sv | 10 +
 rtl/menu_select.sv | 190 +++++++++++++++++++
 tb/tb_menu_select.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/menu_select_if.sv
// Selection handshake between the menu selector and the game controller.
// master drives the pending selection; slave acknowledges it.
interface menu_select_if;
    logic       select_valid;
    logic [1:0] select_id;
    logic       select_ack;

    modport master (output select_valid, output select_id, input select_ack);
    modport slave  (input select_valid, input select_id, output select_ack);
endinterface

// File: rtl/menu_select.sv
// Menu pointer front end: clamps/latches mouse coordinates, hit-tests the three buttons,
// debounces the left button and delivers a press/release selection. Optional macro: MENU_FRAME_LATCH_EN.
module menu_select #(
    parameter int BUTTONS_X       = 412,
    parameter int BUTTONS_W       = 200,
    parameter int BUTTONS_H       = 80,
    parameter int BUTTON1_Y       = 200,
    parameter int BUTTON2_Y       = 340,
    parameter int BUTTON3_Y       = 480,
    parameter int X_MAX           = 1023,
    parameter int Y_MAX           = 767,
    parameter int DEBOUNCE_CYCLES = 65000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [11:0]   mouse_x_i,
    input  logic [11:0]   mouse_y_i,
    input  logic          left_i,
    input  logic          vblnk_i,
    output logic [11:0]   mouse_x,
    output logic [11:0]   mouse_y,
    output logic [1:0]    hover,
    menu_select_if.master sel
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [11:0] X_LIM = 12'(X_MAX);
    localparam logic [11:0] Y_LIM = 12'(Y_MAX);
    localparam logic [11:0] X_LO  = 12'(BUTTONS_X);
    localparam logic [11:0] X_HI  = 12'(BUTTONS_X + BUTTONS_W);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ARMED    = 2'd1;
    localparam logic [1:0] DISARMED = 2'd2;
    localparam logic [1:0] SELECT   = 2'd3;

    logic [11:0] cx, cy;
    logic [11:0] mx_reg, my_reg;

    assign cx = (mouse_x_i > X_LIM) ? X_LIM : mouse_x_i;
    assign cy = (mouse_y_i > Y_LIM) ? Y_LIM : mouse_y_i;

`ifdef MENU_FRAME_LATCH_EN
    logic vblnk_reg;

    // Coordinates only move at the start of vertical blank, never during active video.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vblnk_reg <= 1'b0;
            mx_reg    <= '0;
            my_reg    <= '0;
        end else begin
            vblnk_reg <= vblnk_i;
            if (vblnk_i && !vblnk_reg) begin
                mx_reg <= cx;
                my_reg <= cy;
            end
        end
    end
`else
    logic unused_vblnk;
    assign unused_vblnk = vblnk_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mx_reg <= '0;
            my_reg <= '0;
        end else begin
            mx_reg <= cx;
            my_reg <= cy;
        end
    end
`endif

    assign mouse_x = mx_reg;
    assign mouse_y = my_reg;

    logic [2:0] hit;
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_hit
            localparam int TOP = (gi == 0) ? BUTTON1_Y : ((gi == 1) ? BUTTON2_Y : BUTTON3_Y);
            assign hit[gi] = (mx_reg >= X_LO) && (mx_reg < X_HI) &&
                             (my_reg >= 12'(TOP)) && (my_reg < 12'(TOP + BUTTONS_H));
        end
    endgenerate

    logic [1:0] hover_next, hover_reg;

    // Lowest index wins if regions overlap.
    always_comb begin
        hover_next = 2'd0;
        if (hit[0])      hover_next = 2'd1;
        else if (hit[1]) hover_next = 2'd2;
        else if (hit[2]) hover_next = 2'd3;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) hover_reg <= 2'd0;
        else      hover_reg <= hover_next;
    end

    assign hover = hover_reg;

    logic             sync1_reg, sync2_reg, deb_reg, press_reg, release_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_reg   <= 1'b0;
            sync2_reg   <= 1'b0;
            deb_reg     <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            sync1_reg   <= left_i;
            sync2_reg   <= sync1_reg;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            if (sync2_reg == deb_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                deb_reg     <= ~deb_reg;
                cnt_reg     <= '0;
                press_reg   <= ~deb_reg;
                release_reg <= deb_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    logic [1:0] state_reg, state_next;
    logic [1:0] k_reg, k_next;
    logic [1:0] id_reg, id_next;

    // The release compares against the registered hover, i.e. before any same-cycle latch update lands.
    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        id_next    = id_reg;
        case (state_reg)
            IDLE: begin
                if (press_reg && enable) begin
                    if (hover_reg != 2'd0) begin
                        state_next = ARMED;
                        k_next     = hover_reg;
                    end else begin
                        state_next = DISARMED;
                    end
                end
            end
            ARMED: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (release_reg) begin
                    if (hover_reg == k_reg) begin
                        state_next = SELECT;
                        id_next    = k_reg;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DISARMED: begin
                if (!enable || release_reg) state_next = IDLE;
            end
            SELECT: begin
                if (sel.select_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            k_reg     <= 2'd0;
            id_reg    <= 2'd0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            id_reg    <= id_next;
        end
    end

    assign sel.select_valid = (state_reg == SELECT);
    assign sel.select_id    = id_reg;
endmodule

// File: tb/tb_menu_select.sv
// Self-checking bench for menu_select (debounce shortened to 8 cycles); follows MENU_FRAME_LATCH_EN if defined.
module tb_menu_select;
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ARMED    = 2'd1;
    localparam logic [1:0] ST_DISARMED = 2'd2;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [11:0] mouse_x_i, mouse_y_i;
    logic        left_i;
    logic        vblnk_i;
    logic [11:0] mouse_x, mouse_y;
    logic [1:0]  hover;

    int checks = 0;
    int errors = 0;
    logic [1:0]  exp_q[$];
    logic [11:0] exp_mx, exp_my;

    menu_select_if sif ();

    menu_select #(.DEBOUNCE_CYCLES(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .mouse_x_i (mouse_x_i),
        .mouse_y_i (mouse_y_i),
        .left_i    (left_i),
        .vblnk_i   (vblnk_i),
        .mouse_x   (mouse_x),
        .mouse_y   (mouse_y),
        .hover     (hover),
        .sel       (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive a new pointer position and wait until hover reflects it.
    task automatic move_to(input logic [11:0] x, input logic [11:0] y);
        mouse_x_i = x;
        mouse_y_i = y;
        exp_mx = (x > 12'd1023) ? 12'd1023 : x;
        exp_my = (y > 12'd767) ? 12'd767 : y;
`ifdef MENU_FRAME_LATCH_EN
        tick(1);
        vblnk_i = 1'b1;
        tick(1);
        vblnk_i = 1'b0;
`else
        tick(1);
`endif
        tick(2);
    endtask

    task automatic set_left(input logic level);
        left_i = level;
        tick(14);
    endtask

    task test_reset;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mouse_x_i = 12'(100 * i + 37);
            mouse_y_i = 12'(50 * i + 3);
            left_i = i[0];
            vblnk_i = i[1];
            sif.select_ack = i[0];
            enable = ~i[0];
            tick(1);
            checks++;
            if ({mouse_x, mouse_y, hover, sif.select_valid, sif.select_id} !== 29'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d got x=%0d y=%0d hover=%0d valid=%0d id=%0d required all 0",
                         i, mouse_x, mouse_y, hover, sif.select_valid, sif.select_id);
            end
        end
        left_i = 1'b0; vblnk_i = 1'b0; sif.select_ack = 1'b0; enable = 1'b1;
        mouse_x_i = 12'd100; mouse_y_i = 12'd120;
        rst = 1'b1;
`ifdef MENU_FRAME_LATCH_EN
        tick(5);
        checks++;
        if (mouse_x !== 12'd0) begin
            errors++;
            $display("FAIL reset_no_latch got %0d required 0", mouse_x);
        end
`endif
        move_to(12'd100, 12'd120);
        checks++;
        if (mouse_x !== exp_mx || mouse_y !== exp_my) begin
            errors++;
            $display("FAIL first_coords got %0d,%0d required %0d,%0d", mouse_x, mouse_y, exp_mx, exp_my);
        end
        $display("reset: coords %0d,%0d", mouse_x, mouse_y);
    endtask

    task test_clamp_latch;
        logic [11:0] old_x, old_y;
        old_x = exp_mx; old_y = exp_my;
        mouse_x_i = 12'd1500;
        mouse_y_i = 12'd900;
`ifdef MENU_FRAME_LATCH_EN
        tick(5);
`endif
        checks++;
        if (mouse_x !== old_x || mouse_y !== old_y) begin
            errors++;
            $display("FAIL clamp_hold got %0d,%0d required %0d,%0d", mouse_x, mouse_y, old_x, old_y);
        end
`ifdef MENU_FRAME_LATCH_EN
        vblnk_i = 1'b1;
        tick(1);
        vblnk_i = 1'b0;
`else
        tick(1);
`endif
        checks++;
        if (mouse_x !== 12'd1023 || mouse_y !== 12'd767) begin
            errors++;
            $display("FAIL clamp_value got %0d,%0d required 1023,767", mouse_x, mouse_y);
        end
        $display("clamp: coords %0d,%0d", mouse_x, mouse_y);
        move_to(12'd1023, 12'd767);
    endtask

    task test_hover_edges;
        logic [11:0] tx[7] = '{12'd411, 12'd412, 12'd611, 12'd612, 12'd500, 12'd500, 12'd500};
        logic [11:0] ty[7] = '{12'd200, 12'd200, 12'd279, 12'd279, 12'd340, 12'd559, 12'd560};
        logic [1:0]  th[7] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd3, 2'd0};
        logic [1:0]  want;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(th[i]);
            move_to(tx[i], ty[i]);
            want = exp_q.pop_front();
            checks++;
            if (hover !== want) begin
                errors++;
                $display("FAIL hover_%0d_%0d got %0d required %0d", tx[i], ty[i], hover, want);
            end
            $display("hover: (%0d,%0d) -> %0d", tx[i], ty[i], hover);
        end
    endtask

    task test_debounce;
        int  n;
        bit  seen;
        enable = 1'b0;
        move_to(12'd10, 12'd10);
        left_i = 1'b1;
        tick(5);
        left_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (dut.deb_reg) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL glitch_rejected got 1 required 0");
        end
        left_i = 1'b1;
        n = 0;
        for (int i = 1; i <= 30 && n == 0; i++) begin
            tick(1);
            if (dut.deb_reg) n = i;
        end
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL press_latency got %0d required 10", n);
        end
        tick(6);
        checks++;
        if (dut.state_reg !== ST_IDLE) begin
            errors++;
            $display("FAIL press_disabled_state got %0d required %0d", dut.state_reg, ST_IDLE);
        end
        $display("debounce: press latency %0d", n);
        set_left(1'b0);
        enable = 1'b1;
    endtask

    task test_click;
        bit         found;
        logic [1:0] want;
        move_to(12'd500, 12'd370);
        set_left(1'b1);
        checks++;
        if (dut.state_reg !== ST_ARMED) begin
            errors++;
            $display("FAIL click_armed got %0d required %0d", dut.state_reg, ST_ARMED);
        end
        sif.select_ack = 1'b1;
        tick(1);
        sif.select_ack = 1'b0;
        checks++;
        if (dut.state_reg !== ST_ARMED || sif.select_valid !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack got state %0d valid %0d required %0d 0", dut.state_reg, sif.select_valid, ST_ARMED);
        end
        left_i = 1'b0;
        exp_q.push_back(2'd2);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(1);
            if (sif.select_valid) found = 1'b1;
        end
        want = exp_q.pop_front();
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL click_timeout got valid 0 required 1");
        end else if (sif.select_id !== want) begin
            errors++;
            $display("FAIL click_id got %0d required %0d", sif.select_id, want);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checks++;
            if (sif.select_valid !== 1'b1 || sif.select_id !== want) begin
                errors++;
                $display("FAIL click_hold cycle %0d got valid %0d id %0d required 1 %0d", i, sif.select_valid, sif.select_id, want);
            end
        end
        sif.select_ack = 1'b1;
        tick(1);
        sif.select_ack = 1'b0;
        checks++;
        if (sif.select_valid !== 1'b0 || dut.state_reg !== ST_IDLE) begin
            errors++;
            $display("FAIL click_ack got valid %0d state %0d required 0 %0d", sif.select_valid, dut.state_reg, ST_IDLE);
        end
        $display("click: selected %0d", want);
    endtask

    task automatic release_expect_none(input string name);
        bit seen;
        left_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (sif.select_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || dut.state_reg !== ST_IDLE) begin
            errors++;
            $display("FAIL %s got valid %0d state %0d required 0 %0d", name, seen, dut.state_reg, ST_IDLE);
        end
        $display("cancel: %s", name);
    endtask

    task test_cancel;
        move_to(12'd500, 12'd210);
        set_left(1'b1);
        move_to(12'd500, 12'd370);
        release_expect_none("drag_off");

        move_to(12'd10, 12'd10);
        set_left(1'b1);
        checks++;
        if (dut.state_reg !== ST_DISARMED) begin
            errors++;
            $display("FAIL disarmed_state got %0d required %0d", dut.state_reg, ST_DISARMED);
        end
        move_to(12'd500, 12'd500);
        release_expect_none("drag_on");

        set_left(1'b1);
        enable = 1'b0;
        tick(1);
        checks++;
        if (dut.state_reg !== ST_IDLE) begin
            errors++;
            $display("FAIL enable_drop got %0d required %0d", dut.state_reg, ST_IDLE);
        end
        enable = 1'b1;
        release_expect_none("enable_drop_release");

        checks++;
        if (sif.select_id !== 2'd2) begin
            errors++;
            $display("FAIL id_hold got %0d required 2", sif.select_id);
        end
    endtask

    initial begin
        exp_mx = '0; exp_my = '0;
        test_reset();
        test_clamp_latch();
        test_hover_edges();
        test_debounce();
        test_click();
        test_cancel();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
